// File: rtl/baseline_noise_calc.sv
// baseline_noise_calc: two-pass per-channel baseline (mean) and noise
// (mean absolute deviation) measurement over 2^LOG2_SAMPLES valid ADC frames.
// Pass 1 accumulates raw samples to form the mean; pass 2 accumulates
// |sample - mean| in the DATAWIDTH fixed-point domain. All result words are
// published together in one cycle, so a reader never sees a mixed result set.
module baseline_noise_calc #(
    parameter int ADC_WIDTH    = 8,
    parameter int DATAWIDTH    = 16,
    parameter int ADC_CHANEL   = 8,
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [ADC_CHANEL*ADC_WIDTH-1:0]  adc_data,
    input  logic                             adc_valid,
    output logic                             busy,
    output logic                             done,
    output logic [4:0]                       meas_status,
    output logic [ADC_CHANEL*DATAWIDTH-1:0]  adc_baseline,
    output logic [ADC_CHANEL*DATAWIDTH-1:0]  adc_noise
);

    // Fractional bits of the result format and accumulator widths.
    localparam int FRAC_W = DATAWIDTH - ADC_WIDTH;
    localparam int ACC1_W = ADC_WIDTH + LOG2_SAMPLES;
    localparam int ACC2_W = DATAWIDTH + LOG2_SAMPLES;
    localparam int CNT_W  = LOG2_SAMPLES;

    localparam logic [4:0] ST_WAIT   = 5'd0;
    localparam logic [4:0] ST_START  = 5'd2;
    localparam logic [4:0] ST_FINISH = 5'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS1,
        S_CALC_MEAN,
        S_PASS2,
        S_CALC_NOISE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         status_q, status_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    // Per-channel datapath strobes decoded by the control FSM.
    logic               clr_acc;
    logic               acc1_en;
    logic               acc2_en;
    logic               mean_ld;
    logic               res_ld;
    logic               last_sample;

    // The counter wraps on its last value, so "all ones" marks sample N.
    assign last_sample = (cnt_q == {CNT_W{1'b1}});

    // Control FSM next-state, counter and status decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        done_d   = 1'b0;
        clr_acc  = 1'b0;
        acc1_en  = 1'b0;
        acc2_en  = 1'b0;
        mean_ld  = 1'b0;
        res_ld   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start has priority over abort here; abort alone is a no-op.
                if (start) begin
                    state_d  = S_PASS1;
                    cnt_d    = '0;
                    clr_acc  = 1'b1;
                    status_d = ST_START;
                end
            end
            S_PASS1: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    status_d = ST_WAIT;
                end else if (adc_valid) begin
                    acc1_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_sample) begin
                        state_d = S_CALC_MEAN;
                    end
                end
            end
            S_CALC_MEAN: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    status_d = ST_WAIT;
                end else begin
                    mean_ld = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PASS2;
                end
            end
            S_PASS2: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    status_d = ST_WAIT;
                end else if (adc_valid) begin
                    acc2_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_sample) begin
                        state_d = S_CALC_NOISE;
                    end
                end
            end
            S_CALC_NOISE: begin
                res_ld   = 1'b1;
                done_d   = 1'b1;
                status_d = ST_FINISH;
                state_d  = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                status_d = ST_WAIT;
            end
        endcase
        busy_d = (state_d == S_PASS1) || (state_d == S_CALC_MEAN) ||
                 (state_d == S_PASS2);
    end

    // Control registers; reset returns everything to an idle, zeroed state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            status_q <= ST_WAIT;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign meas_status = status_q;

    genvar gi;
    generate
        for (gi = 0; gi < ADC_CHANEL; gi = gi + 1) begin : g_ch
            logic [ADC_WIDTH-1:0]   sample;
            logic [DATAWIDTH-1:0]   sample_fx;
            logic [ACC2_W-1:0]      acc1_shifted;
            logic [DATAWIDTH-1:0]   mean_calc;
            logic signed [DATAWIDTH:0] diff;
            logic [DATAWIDTH:0]     diff_neg;
            logic [DATAWIDTH-1:0]   mag;
            logic [ACC1_W-1:0]      acc1_q, acc1_d;
            logic [ACC2_W-1:0]      acc2_q, acc2_d;
            logic [DATAWIDTH-1:0]   mean_q, mean_d;
            logic [DATAWIDTH-1:0]   base_q, base_d;
            logic [DATAWIDTH-1:0]   noise_q, noise_d;

            assign sample = adc_data[gi*ADC_WIDTH +: ADC_WIDTH];

            // Fixed-point arithmetic: sample scaling, mean, and |sample - mean|.
            always_comb begin
                sample_fx    = DATAWIDTH'(sample) << FRAC_W;
                acc1_shifted = ACC2_W'(acc1_q) << FRAC_W;
                mean_calc    = acc1_shifted[LOG2_SAMPLES +: DATAWIDTH];
                diff         = $signed({1'b0, sample_fx}) - $signed({1'b0, mean_q});
                diff_neg     = -diff;
                mag          = diff[DATAWIDTH] ? diff_neg[DATAWIDTH-1:0]
                                               : diff[DATAWIDTH-1:0];
            end

            // Accumulator, mean and result-word next values.
            always_comb begin
                acc1_d  = acc1_q;
                acc2_d  = acc2_q;
                mean_d  = mean_q;
                base_d  = base_q;
                noise_d = noise_q;
                if (clr_acc) begin
                    acc1_d = '0;
                    acc2_d = '0;
                end
                if (acc1_en) begin
                    acc1_d = acc1_q + ACC1_W'(sample);
                end
                if (acc2_en) begin
                    acc2_d = acc2_q + ACC2_W'(mag);
                end
                if (mean_ld) begin
                    mean_d = mean_calc;
                end
                // Baseline and noise update together so results are atomic.
                if (res_ld) begin
                    base_d  = mean_q;
                    noise_d = acc2_q[LOG2_SAMPLES +: DATAWIDTH];
                end
            end

            // Per-channel state registers.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    acc1_q  <= '0;
                    acc2_q  <= '0;
                    mean_q  <= '0;
                    base_q  <= '0;
                    noise_q <= '0;
                end else begin
                    acc1_q  <= acc1_d;
                    acc2_q  <= acc2_d;
                    mean_q  <= mean_d;
                    base_q  <= base_d;
                    noise_q <= noise_d;
                end
            end

            assign adc_baseline[gi*DATAWIDTH +: DATAWIDTH] = base_q;
            assign adc_noise[gi*DATAWIDTH +: DATAWIDTH]    = noise_q;
        end
    endgenerate

endmodule

// File: tb/tb_baseline_noise_calc.sv
// Directed bench for baseline_noise_calc with default parameters (8 channels,
// 8-bit samples, 16-bit results, N = 256). Patterns are indexed by the number
// of valid samples already consumed, so gapped runs must match continuous ones.
module tb_baseline_noise_calc;

    localparam int N = 256;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         start;
    logic         abort;
    logic [63:0]  adc_data;
    logic         adc_valid;
    logic         busy;
    logic         done;
    logic [4:0]   meas_status;
    logic [127:0] adc_baseline;
    logic [127:0] adc_noise;

    int tests = 0;
    int fails = 0;

    baseline_noise_calc dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .abort        (abort),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .busy         (busy),
        .done         (done),
        .meas_status  (meas_status),
        .adc_baseline (adc_baseline),
        .adc_noise    (adc_noise)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mode 0: all 0x80. Mode 1: ch3 alternates 0x80/0x82, ch j constant j*0x10.
    // Mode 2: all alternate 0x00/0xFF. Mode 3: all 0xFF.
    function automatic logic [63:0] pat(input int mode, input int k);
        logic [63:0] r;
        logic [7:0]  v;
        r = '0;
        for (int ch = 0; ch < 8; ch++) begin
            case (mode)
                0: v = 8'h80;
                1: v = (ch == 3) ? ((k % 2 == 1) ? 8'h82 : 8'h80) : 8'(ch * 16);
                2: v = (k % 2 == 1) ? 8'hFF : 8'h00;
                default: v = 8'hFF;
            endcase
            r[ch*8 +: 8] = v;
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_base(input int mode);
        logic [127:0] r;
        logic [15:0]  v;
        r = '0;
        for (int ch = 0; ch < 8; ch++) begin
            case (mode)
                0: v = 16'h8000;
                1: v = (ch == 3) ? 16'h8100 : 16'(ch * 16'h1000);
                2: v = 16'h7F80;
                default: v = 16'hFF00;
            endcase
            r[ch*16 +: 16] = v;
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_noise(input int mode);
        logic [127:0] r;
        logic [15:0]  v;
        r = '0;
        for (int ch = 0; ch < 8; ch++) begin
            case (mode)
                1: v = (ch == 3) ? 16'h0100 : 16'h0000;
                2: v = 16'h7F80;
                default: v = 16'h0000;
            endcase
            r[ch*16 +: 16] = v;
        end
        return r;
    endfunction

    // One measurement. intr: 0 none, 1 abort at pass-2 sample 10, 2 reset there.
    // Without an interruption, done must appear exactly 2 + 2N + invalid cycles
    // after the start edge; the step count enforces that.
    task automatic run(input int mode, input bit gaps, input bit mid_start,
                       input bit start_abort, input int intr);
        int  consumed;
        int  guard;
        bit  v;
        adc_valid = 1'b1;
        adc_data  = pat(mode, 0);
        start     = 1'b1;
        abort     = start_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_busy", 128'(busy), 128'd1);
        check("start_status", 128'(meas_status), 128'd2);
        for (int p = 1; p <= 2; p++) begin
            consumed = 0;
            guard    = 0;
            while (consumed < N && guard < 4000) begin
                guard++;
                v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                adc_valid = v;
                adc_data  = pat(mode, consumed);
                start     = (p == 1 && mid_start && consumed == 100);
                if (p == 2 && intr != 0 && consumed == 10) begin
                    if (intr == 1) abort = 1'b1;
                    else sys_rst = 1'b1;
                    step();
                    abort     = 1'b0;
                    sys_rst   = 1'b0;
                    adc_valid = 1'b0;
                    return;
                end
                step();
                if (v) consumed++;
            end
            start = 1'b0;
            if (consumed != N) check("pass_timeout", 128'(consumed), 128'(N));
            if (p == 1) begin
                // CALC_MEAN cycle: valid garbage here must be ignored.
                check("pass1_busy", 128'(busy), 128'd1);
                adc_valid = 1'b1;
                adc_data  = '1;
                step();
            end
        end
        adc_valid = 1'b0;
        check("pre_done", 128'(done), 128'd0);
        step();
        check("done_pulse", 128'(done), 128'd1);
        check("done_busy", 128'(busy), 128'd0);
        check("done_status", 128'(meas_status), 128'd3);
        check("baseline", adc_baseline, exp_base(mode));
        check("noise", adc_noise, exp_noise(mode));
        step();
        check("done_clear", 128'(done), 128'd0);
        check("status_hold", 128'(meas_status), 128'd3);
    endtask

    initial begin
        sys_rst   = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        step();
        step();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_status", 128'(meas_status), 128'd0);
        check("rst_baseline", adc_baseline, 128'd0);
        check("rst_noise", adc_noise, 128'd0);
        sys_rst = 1'b0;
        step();

        run(0, 1'b0, 1'b0, 1'b0, 0);   // constant 0x80, continuous
        $display("[TB] run const80 continuous done");
        run(1, 1'b1, 1'b0, 1'b0, 0);   // ch3 alternating, gapped valid
        $display("[TB] run ch3-alt gapped done");
        run(2, 1'b0, 1'b0, 1'b1, 0);   // 0x00/0xFF, start+abort together
        $display("[TB] run 00/FF start+abort done");

        // abort in IDLE has no effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_status", 128'(meas_status), 128'd3);
        check("idle_abort_base", adc_baseline, exp_base(2));
        $display("[TB] idle abort done");

        run(3, 1'b1, 1'b1, 1'b0, 0);   // 0xFF, gapped, extra start mid-pass1
        $display("[TB] run constFF mid-start done");

        run(2, 1'b0, 1'b0, 1'b0, 1);   // abort mid-pass2
        check("abort_status", 128'(meas_status), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_base", adc_baseline, exp_base(3));
        check("abort_noise", adc_noise, exp_noise(3));
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", 128'(done), 128'd0);
        end
        $display("[TB] abort mid-pass2 done");
        run(0, 1'b0, 1'b0, 1'b0, 0);
        $display("[TB] run after abort done");

        run(1, 1'b0, 1'b0, 1'b0, 2);   // reset mid-pass2
        check("mrst_busy", 128'(busy), 128'd0);
        check("mrst_done", 128'(done), 128'd0);
        check("mrst_status", 128'(meas_status), 128'd0);
        check("mrst_base", adc_baseline, 128'd0);
        check("mrst_noise", adc_noise, 128'd0);
        $display("[TB] reset mid-pass2 done");
        run(1, 1'b1, 1'b0, 1'b0, 0);
        $display("[TB] run after reset done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
